// File: rtl/branch_predictor_bht_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht_pkg
//  Description : Shared constants, default parameters and helpers for the
//                combined BHT/BTB branch predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_bht_pkg;

    localparam int          WORD        = 32;
    localparam logic [31:0] PC_INC      = 32'd4;

    localparam int          DEF_ENTRIES = 64;
    localparam int          DEF_CNT_W   = 2;
    localparam int          DEF_TAG_W   = 8;
    localparam int          DEF_MODE    = 0;
    localparam int          DEF_GHR_W   = 4;

    // Action taken on the table entry selected by an EX resolution.
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TRAIN = 2'd1,
        UPD_ALLOC = 2'd2,
        UPD_INVAL = 2'd3
    } upd_act_e;

    // Initial counter value on allocation: weak taken / weak not-taken.
    // Returned in a 4-bit container (the widest supported counter).
    function automatic logic [3:0] weak_cnt(input logic taken, input int cnt_w);
        int half;
        half = 1 << (cnt_w - 1);
        return taken ? 4'(half) : 4'(half - 1);
    endfunction

endpackage : branch_predictor_bht_pkg
`default_nettype wire

// File: rtl/branch_predictor_bht_sat_counter_update.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter_update
//  Description : Combinational saturating up/down counter step.
//  Ports       : cnt_i  current counter value
//                inc_i  1 = count up, 0 = count down
//                cnt_o  next counter value, clamped at 0 and 2^CNT_W-1
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_update #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != {CNT_W{1'b1}}) cnt_o = cnt_i + 1'b1;
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
        end
    end

endmodule : sat_counter_update
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht
//  Description : Direct-mapped combined BHT/BTB. Looked up with the IF0 PC,
//                prediction registered into IF1. Trained from EX resolution.
//                MODE=0 bimodal indexing, MODE=1 gshare indexing.
//  Ports       : clk, rst (async, active-high)
//                lookup_en_i/lookup_pc_i         IF0 lookup request
//                pred_taken_o/pred_target_o/pred_hit_o  IF1 prediction
//                upd_valid_i/upd_pc_i/upd_is_branch_i/upd_taken_i/
//                upd_target_i                    EX resolution
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int MODE    = DEF_MODE,
    parameter int GHR_W   = DEF_GHR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lookup_en_i,
    input  logic [WORD-1:0] lookup_pc_i,
    output logic            pred_taken_o,
    output logic [WORD-1:0] pred_target_o,
    output logic            pred_hit_o,
    input  logic            upd_valid_i,
    input  logic [WORD-1:0] upd_pc_i,
    input  logic            upd_is_branch_i,
    input  logic            upd_taken_i,
    input  logic [WORD-1:0] upd_target_i
);

    localparam int IDX_W = $clog2(ENTRIES);

    // ------------------------------------------------------------------
    // Table storage. Only the valid bits are reset; every read of the
    // other arrays is qualified by valid so their power-up contents never
    // reach the outputs.
    // ------------------------------------------------------------------
    logic             valid_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [WORD-1:0]  tgt_q   [ENTRIES];

    logic [IDX_W-1:0] ghr_ext;

    // ------------------------------------------------------------------
    // Global history (gshare only)
    // ------------------------------------------------------------------
    generate
        if (MODE == 1) begin : g_gshare
            logic [GHR_W-1:0] ghr_q;
            logic [GHR_W-1:0] ghr_d;

            if (GHR_W == 1) begin : g_ghr_one
                assign ghr_d = upd_taken_i;
            end else begin : g_ghr_shift
                assign ghr_d = {ghr_q[GHR_W-2:0], upd_taken_i};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr_q <= '0;
                end else if (upd_valid_i && upd_is_branch_i) begin
                    ghr_q <= ghr_d;
                end
            end

            assign ghr_ext = IDX_W'(ghr_q);
        end else begin : g_bimodal
            assign ghr_ext = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Index / tag formation. Both ports use the GHR value held before any
    // update of this cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;

    assign lk_idx = lookup_pc_i[IDX_W+1:2] ^ ghr_ext;
    assign up_idx = upd_pc_i[IDX_W+1:2]    ^ ghr_ext;
    assign lk_tag = lookup_pc_i[IDX_W+2 +: TAG_W];
    assign up_tag = upd_pc_i[IDX_W+2 +: TAG_W];

    // ------------------------------------------------------------------
    // Lookup path (reads pre-update contents; no bypass)
    // ------------------------------------------------------------------
    logic            lk_hit;
    logic            lk_taken;
    logic [WORD-1:0] lk_target;

    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign lk_target = lk_taken ? tgt_q[lk_idx] : (lookup_pc_i + PC_INC);

    logic            pred_taken_q;
    logic            pred_hit_q;
    logic [WORD-1:0] pred_target_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_taken_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
        end else if (lookup_en_i) begin
            pred_taken_q  <= lk_taken;
            pred_hit_q    <= lk_hit;
            pred_target_q <= lk_target;
        end
    end

    assign pred_taken_o  = pred_taken_q;
    assign pred_hit_o    = pred_hit_q;
    assign pred_target_o = pred_target_q;

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic             up_hit;
    upd_act_e         up_act;
    logic [CNT_W-1:0] cnt_step;
    logic [3:0]       cnt_weak;

    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign cnt_weak = weak_cnt(upd_taken_i, CNT_W);

    always_comb begin
        up_act = UPD_NONE;
        if (upd_valid_i) begin
            if (upd_is_branch_i) begin
                up_act = up_hit ? UPD_TRAIN : UPD_ALLOC;
            end else if (up_hit) begin
                // A non-branch matching an entry means that entry aliases
                // onto straight-line code: drop it.
                up_act = UPD_INVAL;
            end
        end
    end

    sat_counter_update #(
        .CNT_W (CNT_W)
    ) u_sat (
        .cnt_i (cnt_q[up_idx]),
        .inc_i (upd_taken_i),
        .cnt_o (cnt_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            case (up_act)
                UPD_ALLOC: valid_q[up_idx] <= 1'b1;
                UPD_INVAL: valid_q[up_idx] <= 1'b0;
                default:   ;
            endcase
        end
    end

    // Data arrays carry no reset; a write racing with reset is harmless
    // because the entry's valid bit is held clear.
    always_ff @(posedge clk) begin
        case (up_act)
            UPD_TRAIN: begin
                cnt_q[up_idx] <= cnt_step;
                if (upd_taken_i) tgt_q[up_idx] <= upd_target_i;
            end
            UPD_ALLOC: begin
                cnt_q[up_idx] <= cnt_weak[CNT_W-1:0];
                tag_q[up_idx] <= up_tag;
                tgt_q[up_idx] <= upd_target_i;
            end
            default: ;
        endcase
    end

endmodule : branch_predictor_bht
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bht
//  Description : Self-checking bench for branch_predictor_bht. Runs a bimodal
//                and a gshare instance side by side on the same stimulus and
//                compares both against a table-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int TAG_W   = 8;
    localparam int GHR_W   = 4;
    localparam int IDX_W   = 6;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_branch = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;

    logic        pt [2];
    logic        ph [2];
    logic [31:0] pg [2];

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .ENTRIES(ENTRIES), .CNT_W(CNT_W), .TAG_W(TAG_W), .MODE(0), .GHR_W(GHR_W)
    ) dut_b (
        .clk(clk), .rst(rst),
        .lookup_en_i(lookup_en), .lookup_pc_i(lookup_pc),
        .pred_taken_o(pt[0]), .pred_target_o(pg[0]), .pred_hit_o(ph[0]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_is_branch_i(upd_is_branch),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target)
    );

    branch_predictor_bht #(
        .ENTRIES(ENTRIES), .CNT_W(CNT_W), .TAG_W(TAG_W), .MODE(1), .GHR_W(GHR_W)
    ) dut_g (
        .clk(clk), .rst(rst),
        .lookup_en_i(lookup_en), .lookup_pc_i(lookup_pc),
        .pred_taken_o(pt[1]), .pred_target_o(pg[1]), .pred_hit_o(ph[1]),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_is_branch_i(upd_is_branch),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target)
    );

    // ---------------- reference model (per mode: 0 bimodal, 1 gshare) ---
    bit          m_valid [2][ENTRIES];
    int          m_tag   [2][ENTRIES];
    int          m_cnt   [2][ENTRIES];
    logic [31:0] m_tgt   [2][ENTRIES];
    int          m_ghr   [2];
    bit          e_hit   [2];
    bit          e_taken [2];
    logic [31:0] e_tgt   [2];

    int n_pass  = 0;
    int n_total = 0;

    function automatic int idx_of(int m, logic [31:0] pc);
        int i;
        i = int'((pc >> 2) % ENTRIES);
        if (m == 1) i = i ^ m_ghr[1];
        return i;
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[m][i] = 1'b0;
            m_ghr[m]   = 0;
            e_hit[m]   = 1'b0;
            e_taken[m] = 1'b0;
            e_tgt[m]   = 32'h0;
        end
    endtask

    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            int  li, ui;
            bit  hit;
            li = idx_of(m, lookup_pc);
            ui = idx_of(m, upd_pc);
            if (lookup_en) begin
                e_hit[m]   = m_valid[m][li] && (m_tag[m][li] == tag_of(lookup_pc));
                e_taken[m] = e_hit[m] && (m_cnt[m][li] >= (1 << (CNT_W - 1)));
                e_tgt[m]   = e_taken[m] ? m_tgt[m][li] : lookup_pc + 32'd4;
            end
            if (upd_valid) begin
                hit = m_valid[m][ui] && (m_tag[m][ui] == tag_of(upd_pc));
                if (upd_is_branch) begin
                    if (hit) begin
                        if (upd_taken) begin
                            if (m_cnt[m][ui] < CMAX) m_cnt[m][ui]++;
                            m_tgt[m][ui] = upd_target;
                        end else if (m_cnt[m][ui] > 0) begin
                            m_cnt[m][ui]--;
                        end
                    end else begin
                        m_valid[m][ui] = 1'b1;
                        m_tag[m][ui]   = tag_of(upd_pc);
                        m_cnt[m][ui]   = upd_taken ? (1 << (CNT_W - 1)) : (1 << (CNT_W - 1)) - 1;
                        m_tgt[m][ui]   = upd_target;
                    end
                    if (m == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(upd_taken)) % (1 << GHR_W);
                end else if (hit) begin
                    m_valid[m][ui] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic chk_model();
        for (int m = 0; m < 2; m++) begin
            chk(m == 0 ? "bim_hit"    : "gsh_hit",    32'(ph[m]), 32'(e_hit[m]));
            chk(m == 0 ? "bim_taken"  : "gsh_taken",  32'(pt[m]), 32'(e_taken[m]));
            chk(m == 0 ? "bim_target" : "gsh_target", pg[m],      e_tgt[m]);
        end
    endtask

    // One clock: model sees the same pre-edge inputs as the DUT.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_clock();
        #1;
        chk_model();
    endtask

    task automatic drive(input bit le, input logic [31:0] lpc,
                         input bit uv, input logic [31:0] upc, input bit br,
                         input bit tk, input logic [31:0] tgt);
        lookup_en = le;  lookup_pc = lpc;
        upd_valid = uv;  upd_pc = upc;  upd_is_branch = br;
        upd_taken = tk;  upd_target = tgt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [31:0] PA = 32'h1C00_0010;
    localparam logic [31:0] PB = 32'h1C00_0020;
    localparam logic [31:0] PC = 32'h1C00_0030;
    localparam logic [31:0] PD = 32'h1C00_0040;
    localparam logic [31:0] ALIAS = 32'h0001_0000; // ENTRIES*4*2^TAG_W

    initial begin
        // Reset state and first lookup
        do_reset();
        drive(1, 32'h1C00_0000, 0, 0, 0, 0, 0);
        cycle();
        chk("first_hit",    32'(ph[0]), 32'h0);
        chk("first_taken",  32'(pt[0]), 32'h0);
        chk("first_target", pg[0],      32'h1C00_0004);

        // PC+4 wraps at the top of the address space
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        cycle();
        chk("wrap_target", pg[0], 32'h0000_0000);

        // Allocate weak-taken, then look it up
        drive(0, 0, 1, PA, 1, 1, 32'h1C00_0100);
        cycle();
        drive(1, PA, 0, 0, 0, 0, 0);
        cycle();
        chk("alloc_taken",  32'(pt[0]), 32'h1);
        chk("alloc_target", pg[0],      32'h1C00_0100);

        // Two not-taken updates bring the counter to 0
        drive(0, 0, 1, PA, 1, 0, 32'h0);
        cycle();
        cycle();
        drive(1, PA, 0, 0, 0, 0, 0);
        cycle();
        chk("nt_taken",  32'(pt[0]), 32'h0);
        chk("nt_target", pg[0],      32'h1C00_0014);

        // Saturation: five taken then one not-taken still predicts taken
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, PB, 1, 1, 32'h1C00_0200);
            cycle();
        end
        drive(0, 0, 1, PB, 1, 0, 32'h0);
        cycle();
        drive(1, PB, 0, 0, 0, 0, 0);
        cycle();
        chk("sat_taken", 32'(pt[0]), 32'h1);

        // Aliasing cleanup
        drive(0, 0, 1, PC, 1, 1, 32'h1C00_0300);
        cycle();
        drive(0, 0, 1, PC + ALIAS, 0, 0, 0);
        cycle();
        drive(1, PC, 0, 0, 0, 0, 0);
        cycle();
        chk("alias_cleared", 32'(ph[0]), 32'h0);
        drive(0, 0, 1, PC, 1, 1, 32'h1C00_0300);
        cycle();
        drive(0, 0, 1, PC + 32'h100, 0, 0, 0);
        cycle();
        drive(1, PC, 0, 0, 0, 0, 0);
        cycle();
        chk("alias_kept", 32'(ph[0]), 32'h1);

        // Same-cycle update/lookup: lookup sees old contents
        drive(1, PB, 1, PB, 1, 0, 0);
        cycle();
        drive(1, PB, 1, PB, 1, 0, 0);
        cycle();
        drive(1, PB, 0, 0, 0, 0, 0);
        cycle();

        // Hold while lookup_en=0 and the PC moves
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h1C00_0000 + 32'(i * 4), 0, 0, 0, 0, 0);
            cycle();
        end

        // Gshare history T,T,N,T then a lookup on the same PC
        do_reset();
        drive(0, 0, 1, PD, 1, 1, 32'h1C00_0400); cycle();
        drive(0, 0, 1, PD, 1, 1, 32'h1C00_0400); cycle();
        drive(0, 0, 1, PD, 1, 0, 32'h1C00_0400); cycle();
        drive(0, 0, 1, PD, 1, 1, 32'h1C00_0400); cycle();
        chk("ghr_model", 32'(m_ghr[1]), 32'hD);
        drive(1, PD, 0, 0, 0, 0, 0);
        cycle();

        // Reset with an update pending: everything misses afterwards
        drive(1, PD, 1, PD, 1, 1, 32'h1C00_0500);
        do_reset();
        drive(1, PD, 0, 0, 0, 0, 0);
        cycle();
        chk("rst_bim_miss", 32'(ph[0]), 32'h0);
        chk("rst_gsh_miss", 32'(ph[1]), 32'h0);

        // Randomized traffic over a small PC pool to force hits and aliases
        for (int n = 0; n < 600; n++) begin
            logic [31:0] lp, up;
            lp = 32'h1C00_0000 | (32'($urandom_range(0, 23)) << 2);
            up = 32'h1C00_0000 | (32'($urandom_range(0, 23)) << 2);
            if ($urandom_range(0, 7) == 0) up = up | ALIAS;
            if ($urandom_range(0, 31) == 0) lp = 32'hFFFF_FFFC;
            drive($urandom_range(0, 3) != 0, lp,
                  $urandom_range(0, 1) == 1, up, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 1) == 1, $urandom);
            if (n == 300) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_branch_predictor_bht
`default_nettype wire

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised successor to the single-counter 2-bit predictor used by the IF0/IF1 front end.
- Holds a direct-mapped table of ENTRIES saturating counters with tags and branch targets (combined BHT/BTB).
- Lookup uses the IF0 PC; the registered prediction is presented in IF1, where Pre_Branch/Pre_PC are formed.
- Trained non-speculatively from EX branch resolution. Supports bimodal or gshare indexing.

Parameters:
- ENTRIES, 64, table depth; power of two, 4..1024; IDX_W = log2(ENTRIES).
- CNT_W, 2, saturating counter width, 1..4.
- TAG_W, 8, stored tag bits taken from PC[IDX_W+2 +: TAG_W]; IDX_W+2+TAG_W <= 32.
- MODE, 0, 0 = bimodal (idx = PC[IDX_W+1:2]); 1 = gshare (idx = PC[IDX_W+1:2] XOR zero-extended GHR).
- GHR_W, 4, global history width, 1..IDX_W; unused when MODE=0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- lookup_en  in  1  capture new lookup; low = hold (IF stall)
- lookup_pc  in  32  IF0 PC
- pred_taken  out  1  IF1 predicted-taken
- pred_target  out  32  IF1 predicted next PC
- pred_hit  out  1  IF1 tag hit indicator
- upd_valid  in  1  EX resolution valid this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_is_branch  in  1  instruction is a branch/jump
- upd_taken  in  1  resolved direction
- upd_target  in  32  resolved target

Behaviour:
- One clock domain. Reset is asynchronous and active-high, on rst. Clock is clk.
- Reset state:
  - All valid bits are 0 and GHR is 0.
  - pred_taken=0, pred_hit=0, pred_target=0.
  - Counter, tag and target arrays need no reset; valid gates them.
- Lookup latency is 1 cycle:
  - On a posedge with lookup_en=1, index and tag are computed from lookup_pc and the current GHR.
  - The result is registered into pred_*.
  - With lookup_en=0, pred_* hold their previous values.
- Prediction rule:
  - hit = valid[idx] && tag[idx]==lookup tag.
  - pred_hit = hit.
  - pred_taken = hit && counter MSB==1.
  - pred_target = stored target when pred_taken, else lookup_pc+4 (32-bit wrap, so 0xFFFFFFFC -> 0x00000000).
- Update applies on a posedge with upd_valid=1. Index uses upd_pc and the GHR value before this update.
  - is_branch, tag hit: counter saturating +1 if taken, -1 if not taken (clamped at 0 and 2^CNT_W-1). Target is written only if taken.
  - is_branch, miss: allocate by overwriting the entry. Set valid=1 and the tag. Counter = 2^(CNT_W-1) (weak taken) if taken, else 2^(CNT_W-1)-1 (weak not-taken). Target = upd_target.
  - not is_branch, tag hit: clear valid (aliasing cleanup).
  - not is_branch, miss: no change.
  - GHR (MODE=1): on every branch update, GHR <= {GHR[GHR_W-2:0], upd_taken}. It does not change on non-branch updates.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (read-old, no bypass). The updated value is seen from the next lookup.
- Simultaneous lookup and GHR change: lookup uses the pre-update GHR.
- CNT_W=1 degenerates to a last-outcome bit. Weak not-taken = 0, weak taken = 1.
- Reset mid-operation: all state returns to the reset values immediately. A pending update is lost.
- No X propagation: a lookup on an invalid entry must never drive stored array contents onto outputs.

Decomposition:
- Shared CPU_Parameter.vh gains: WORD, predictor default parameters, and the PC_INC constant (4).
- One natural sub-module: sat_counter_update. It is combinational: given current value, dir and CNT_W, it returns the next value.
- Arrays are inferred as distributed RAM / register file inside branch_predictor_bht.

Test Plan:
- Reset then lookup 0x1C000000 -> next cycle pred_hit=0, pred_taken=0, pred_target=0x1C000004.
- Update pc=0x1C000010 taken target=0x1C000100 (miss, alloc weak-taken=2); lookup same PC -> pred_taken=1, pred_target=0x1C000100. Then two not-taken updates -> counter 0, lookup gives pred_taken=0, pred_target=0x1C000014.
- Saturation: five taken updates on one PC -> counter stays 3. One not-taken -> counter 2, still predicts taken.
- Alias: alloc 0x1C000010. Update non-branch pc=0x1C000010+ENTRIES*4*2^TAG_W (same idx and tag bits) -> valid cleared. Different-tag non-branch -> no change.
- Same-cycle update and lookup to the same idx -> lookup shows old counter. lookup_en=0 for 3 cycles while pc changes -> outputs held.
- MODE=1, GHR_W=4: updates T,T,N,T set GHR=1101b. Lookup of the same PC indexes idx^0xD. Assert rst mid-sequence -> GHR=0, all lookups miss.
